// File: rtl/reg32b_arb.sv
// reg32b_arb: round-robin arbiter giving two masters shared access to a
// single-port register file. Each granted transaction runs IDLE -> ACCESS ->
// RESP -> IDLE. The command is latched on entry to ACCESS. Read data is
// captured at the end of ACCESS. The ack pulses for one cycle in RESP.
//
// Ports
//   clk, reset_           clock, asynchronous active-low reset
//   mN_req/we_/addr/wdata master N command (we_: 0 = write, 1 = read)
//   mN_gnt                master N owns the register file (ACCESS)
//   mN_ack                master N transaction complete (RESP, 1 cycle)
//   mN_rdata              master N read data, held until its next read
//   rf_addr/rf_d_in/rf_we_  register file command (idle values outside ACCESS)
//   rf_d_out              register file read data, combinational from rf_addr
//   busy                  arbiter in ACCESS or RESP
module reg32b_arb #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              m0_req,
  input  logic              m0_we_,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we_,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_d_in,
  output logic              rf_we_,
  input  logic [DATA_W-1:0] rf_d_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Latched command owner and direction. The latched address and write data
  // live directly in the rf_addr / rf_d_in output registers.
  logic cmd_sel;
  logic cmd_we_;
  // Master served most recently (0 = m0, 1 = m1).
  logic last;

  logic              take;
  logic              pick;
  logic              sel_we_;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // State register
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and round-robin selection
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    pick      = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          take      = 1'b1;
          state_nxt = ACCESS;
          // On a tie the master not served last wins.
          pick      = (m0_req && m1_req) ? ~last : m1_req;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command of the selected master
  always_comb begin
    sel_we_   = pick ? m1_we_   : m0_we_;
    sel_addr  = pick ? m1_addr  : m0_addr;
    sel_wdata = pick ? m1_wdata : m0_wdata;
  end

  // Command latch, arbitration history and registered outputs
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cmd_sel  <= 1'b0;
      cmd_we_  <= 1'b1;
      last     <= 1'b1;
      m0_gnt   <= 1'b0;
      m1_gnt   <= 1'b0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      busy     <= 1'b0;
      rf_we_   <= 1'b1;
      rf_addr  <= '0;
      rf_d_in  <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      if (take) begin
        cmd_sel <= pick;
        cmd_we_ <= sel_we_;
        last    <= pick;
      end
      busy    <= (state_nxt != IDLE);
      m0_gnt  <= take && !pick;
      m1_gnt  <= take && pick;
      m0_ack  <= (state == ACCESS) && !cmd_sel;
      m1_ack  <= (state == ACCESS) && cmd_sel;
      // Register-file command is driven only for the ACCESS cycle.
      rf_we_  <= !(take && !sel_we_);
      rf_addr <= take ? sel_addr : '0;
      rf_d_in <= (take && !sel_we_) ? sel_wdata : '0;
      // Read data is captured as ACCESS ends, while rf_addr is still valid.
      if ((state == ACCESS) && cmd_we_) begin
        if (cmd_sel) m1_rdata <= rf_d_out;
        else         m0_rdata <= rf_d_out;
      end
    end
  end

endmodule

// File: doc/reg32b_arb.md
REG32B_ARB -- requirements
Module: reg32b_arb

Interface
REQ-001 The block SHALL declare the following parameters:
- ADDR_W, default 5, register address width.
- DATA_W, default 32, register data width.
REQ-002 The block SHALL declare the following ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 access request; active-high.
- m0_we_  in  1  master 0 direction; 0 = write, 1 = read.
- m0_addr  in  ADDR_W  master 0 register address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  master 0 owns the register file this cycle.
- m0_ack  out  1  master 0 transaction complete; 1-cycle pulse.
- m0_rdata  out  DATA_W  master 0 read data.
- m1_req, m1_we_, m1_addr, m1_wdata, m1_gnt, m1_ack, m1_rdata: same directions, widths and meanings for master 1.
- rf_addr  out  ADDR_W  register file address.
- rf_d_in  out  DATA_W  register file write data.
- rf_we_  out  1  register file write enable; active-low.
- rf_d_out  in  DATA_W  register file read data; combinational from rf_addr.
- busy  out  1  arbiter is in ACCESS or RESP.

Function
REQ-003 The arbiter SHALL implement three states: IDLE, ACCESS and RESP.
REQ-004 In IDLE at a rising edge, with any mN_req high, the arbiter SHALL:
- select one master;
- latch that master's we_, addr and wdata into internal command registers;
- move to ACCESS.
REQ-005 In IDLE with no request, the arbiter SHALL stay in IDLE.
REQ-006 The arbiter SHALL always go ACCESS -> RESP and RESP -> IDLE, each after exactly one cycle.
REQ-007 Each transaction SHALL take 3 cycles:
- request sampled at edge k;
- gnt high in cycle k..k+1;
- ack high in cycle k+1..k+2;
- back in IDLE after edge k+2.
REQ-008 Arbitration SHALL be round-robin:
- with one request pending, that master wins;
- with both pending, the master NOT served last wins;
- after reset, master 0 counts as not-last (m0 wins the first tie).
REQ-009 The last-served indicator SHALL update only on entry to ACCESS.
REQ-010 mN_gnt SHALL be high only during ACCESS, and only for the selected master.
REQ-011 In ACCESS, rf_addr SHALL equal the latched address.
REQ-012 In ACCESS for a write:
- rf_d_in SHALL equal the latched wdata;
- rf_we_ SHALL be 0.
REQ-013 In ACCESS for a read:
- rf_we_ SHALL be 1;
- rf_d_in SHALL be 0;
- mN_rdata of the selected master SHALL load rf_d_out at the ACCESS -> RESP edge.
REQ-014 Outside ACCESS, rf_we_ SHALL be 1 and rf_addr and rf_d_in SHALL be 0; no register-file write is possible outside ACCESS.
REQ-015 mN_ack SHALL be high only during RESP, for the served master, for exactly one cycle.
REQ-016 mN_rdata SHALL hold its value until that master's next read completes.
REQ-017 Writes SHALL NOT change either master's rdata, and a read by one master SHALL NOT change the other master's rdata.
REQ-018 Once a command is latched, it SHALL complete unchanged even if mN_req, addr, wdata or we_ change or drop during ACCESS/RESP.
REQ-019 Masters SHALL hold req and command stable until ack and drop req in the cycle after ack. A request still high when the arbiter returns to IDLE SHALL be treated as a new request.
REQ-020 Requests arriving during ACCESS/RESP SHALL be ignored until IDLE. They SHALL NOT be lost while req stays high.
REQ-021 busy SHALL be high exactly in ACCESS and RESP.
REQ-022 Back-to-back alternating requests SHALL each be served within 6 cycles of being sampled in IDLE (no starvation).

Reset
REQ-023 On reset_ low, the block SHALL asynchronously force:
- state = IDLE;
- m0_gnt, m1_gnt, m0_ack, m1_ack, busy = 0;
- rf_we_ = 1, rf_addr = 0, rf_d_in = 0;
- m0_rdata, m1_rdata = 0;
- last-served = master 1.
REQ-024 A reset asserted during ACCESS SHALL abort the transaction:
- rf_we_ returns to 1 immediately;
- no ack is issued;
- rdata stays 0.
REQ-025 The block SHALL leave reset only on a rising edge of clk after reset_ goes high. The first evaluated state is IDLE.

Verification
REQ-026 Single write then read: m0 write addr 5 = 0x0000_00A5, then m0 read addr 5 -> rf_we_ low for exactly one cycle with rf_addr=5; m0_ack pulses twice; m0_rdata=0x0000_00A5.
REQ-027 Simultaneous requests after reset: m0 and m1 both read in the same cycle -> m0 granted first, m1 granted in the next transaction. Repeated contention alternates m1, m0, m1...
REQ-028 Full sweep: m1 writes value i to addr i for i=0..31, then m0 reads all 32 -> every m0_rdata == i; m1_rdata remains 0.
REQ-029 Command change mid-transaction: m0 write addr 3 = 0x1234; during ACCESS, m0_addr changes to 7 and m0_wdata to 0xFFFF -> the register file sees addr 3 with data 0x1234.
REQ-030 Reset mid-transaction: reset_ pulsed low during the ACCESS of an m1 write -> rf_we_=1 immediately; no m1_ack; a subsequent read of that addr returns the pre-write contents.
REQ-031 Idle behaviour: no requests for 10 cycles -> busy=0, rf_we_=1, rf_addr=0 and both gnt/ack lines low throughout.
